// File: rtl/seu_event_counter_mc.sv
// seu_event_counter_mc: multi-channel SEU event counter.
// Each channel synchronises its asynchronous SEU input, stretches it through a
// hold-window glitch filter, and counts rising edges of the filtered level.
// Counters can be snapshotted atomically into shadow registers and read back
// through a two-stage read pipeline.
// Build option: define SEU_CNT_SATURATE_EN to make counters stick at all-ones
// on overflow instead of wrapping to zero.

// Per-channel datapath: synchroniser, glitch filter, event counter, shadow.
module seu_event_counter_mc_lane #(
  parameter int CW          = 32,
  parameter int FILT        = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seu_in,
  input  logic          ch_en,
  input  logic          clr,
  input  logic          snap,
  output logic          filt_q,
  output logic [CW-1:0] shd_cnt,
  output logic          shd_ovf
);
  localparam logic [7:0] FILT_L = 8'(FILT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             hold_q;
  logic                   filt_d;
  logic [CW-1:0]          cnt_q;
  logic                   ovf_q;
  logic                   synced;
  logic                   inc;

  assign synced = sync_q[SYNC_STAGES-1];
  // a filtered rising edge is detected one cycle after filt_q rises
  assign inc    = filt_q & ~filt_d & ch_en;

  // synchroniser chain for the asynchronous SEU input
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], seu_in};

  // hold-window filter: any high sample re-arms the window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_q <= '0;
      filt_q <= 1'b0;
    end else if (synced) begin
      hold_q <= FILT_L;
      filt_q <= 1'b1;
    end else if (hold_q != 8'd0) begin
      hold_q <= hold_q - 8'd1;
    end else begin
      filt_q <= 1'b0;
    end

  // previous filtered level for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) filt_d <= 1'b0;
    else     filt_d <= filt_q;

  // event counter with sticky overflow; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_q <= 1'b1;
`ifdef SEU_CNT_SATURATE_EN
        cnt_q <= cnt_q;
`else
        cnt_q <= '0;
`endif
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

  // shadow copy takes the pre-update counter value, so snap+clr is read-and-clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shd_cnt <= '0;
      shd_ovf <= 1'b0;
    end else if (snap) begin
      shd_cnt <= cnt_q;
      shd_ovf <= ovf_q;
    end
endmodule

// Top: NCH lanes plus the shared shadow read port.
module seu_event_counter_mc #(
  parameter int NCH         = 4,
  parameter int CW          = 32,
  parameter int FILT        = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] seu_in,
  input  logic [NCH-1:0] ch_en,
  input  logic           clr,
  input  logic           snap,
  input  logic           rd_req,
  input  logic [3:0]     rd_sel,
  output logic           rd_valid,
  output logic [CW-1:0]  rd_data,
  output logic           rd_ovf,
  output logic           rd_err,
  output logic [NCH-1:0] seu_active
);
  typedef struct packed {
    logic [CW-1:0] data;
    logic          ovf;
    logic          err;
  } rd_rsp_t;

  logic [NCH-1:0][CW-1:0] shd_cnt;
  logic [NCH-1:0]         shd_ovf;
  logic [1:0]             vld_pipe;
  rd_rsp_t                sel_rsp;
  rd_rsp_t                rsp_q;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    seu_event_counter_mc_lane #(
      .CW(CW), .FILT(FILT), .SYNC_STAGES(SYNC_STAGES)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .seu_in (seu_in[g]),
      .ch_en  (ch_en[g]),
      .clr    (clr),
      .snap   (snap),
      .filt_q (seu_active[g]),
      .shd_cnt(shd_cnt[g]),
      .shd_ovf(shd_ovf[g])
    );
  end

  // shadow select; out-of-range channels read as zero with the error flag
  always_comb begin
    sel_rsp     = '0;
    sel_rsp.err = ({28'd0, rd_sel} >= 32'(NCH));
    for (int i = 0; i < NCH; i++)
      if (rd_sel == 4'(i)) begin
        sel_rsp.data = shd_cnt[i];
        sel_rsp.ovf  = shd_ovf[i];
      end
  end

  // read pipeline: capture at the request edge, present one edge later;
  // outputs only move when a response is delivered, so they hold otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      rsp_q    <= '0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_req};
      if (rd_req) rsp_q <= sel_rsp;
      if (vld_pipe[0]) begin
        rd_data <= rsp_q.data;
        rd_ovf  <= rsp_q.ovf;
        rd_err  <= rsp_q.err;
      end
    end

  assign rd_valid = vld_pipe[1];
endmodule

// File: tb/tb_seu_event_counter_mc.sv
// Scoreboard bench for seu_event_counter_mc: a 32-bit and an 8-bit counter
// instance share stimulus; a window-based reference model predicts filtered
// levels, event counts and read responses.
`timescale 1ns/1ps
module tb_seu_event_counter_mc;
  localparam int NCH = 4, FILT = 7, SS = 2;

  logic           clk = 1'b0, rst = 1'b1;
  logic [NCH-1:0] seu_in = '0, ch_en = '1;
  logic           clr = 1'b0, snap = 1'b0, rd_req = 1'b0;
  logic [3:0]     rd_sel = '0;

  logic           rv_a, ro_a, re_a, rv_b, ro_b, re_b;
  logic [31:0]    rd_a;
  logic [7:0]     rd_b;
  logic [NCH-1:0] act_a, act_b;

  seu_event_counter_mc #(.NCH(NCH), .CW(32), .FILT(FILT), .SYNC_STAGES(SS)) dut_a (
    .clk(clk), .rst(rst), .seu_in(seu_in), .ch_en(ch_en), .clr(clr), .snap(snap),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rv_a), .rd_data(rd_a),
    .rd_ovf(ro_a), .rd_err(re_a), .seu_active(act_a));

  seu_event_counter_mc #(.NCH(NCH), .CW(8), .FILT(FILT), .SYNC_STAGES(SS)) dut_b (
    .clk(clk), .rst(rst), .seu_in(seu_in), .ch_en(ch_en), .clr(clr), .snap(snap),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rv_b), .rd_data(rd_b),
    .rd_ovf(ro_b), .rd_err(re_b), .seu_active(act_b));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    int     due;
    longint n;
    bit     err;
  } exp_t;

  exp_t           q[2][$];
  bit [NCH-1:0]   raw[$];      // seu_in as seen at each edge since reset
  longint         cnt[NCH];    // events since last clear
  longint         shd[NCH];    // event count captured at last snap
  int             last_t = -1;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, got, exp, last_t);
    end
  endtask

  // filtered level after edge k: any high synced sample in the last FILT+1 edges
  function automatic bit filt_at(input int k, input int ch);
    bit [NCH-1:0] v;
    for (int j = k - FILT; j <= k; j++)
      if (j - SS >= 0 && j - SS < raw.size()) begin
        v = raw[j - SS];
        if (v[ch]) return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic longint exp_val(input longint n, input int cw);
    longint cap;
    cap = longint'(1) << cw;
`ifdef SEU_CNT_SATURATE_EN
    return (n >= cap) ? cap - 1 : n;
`else
    return n % cap;
`endif
  endfunction

  // reference model
  exp_t em;
  int   mt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      raw.delete(); q[0].delete(); q[1].delete();
      for (int c = 0; c < NCH; c++) begin cnt[c] = 0; shd[c] = 0; end
      last_t = -1;
    end else begin
      raw.push_back(seu_in);
      mt = raw.size() - 1;
      if (rd_req) begin
        em.due = mt + 1;
        em.err = (rd_sel >= NCH);
        em.n   = em.err ? 0 : shd[rd_sel];
        q[0].push_back(em);
        q[1].push_back(em);
      end
      if (snap) for (int c = 0; c < NCH; c++) shd[c] = cnt[c];
      for (int c = 0; c < NCH; c++)
        if (clr) cnt[c] = 0;
        else if (ch_en[c] && filt_at(mt - 1, c) && !filt_at(mt - 2, c)) cnt[c]++;
      last_t = mt;
    end
  end

  // monitor
  exp_t           ex;
  logic           mv, mo, me;
  longint         md;
  int             mcw;
  logic [NCH-1:0] act_exp;
  longint         pd[2];
  logic           po[2], pe[2];
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outs_a", {rv_a, ro_a, re_a, |rd_a, |act_a}, 0);
      chk("rst_outs_b", {rv_b, ro_b, re_b, |rd_b, |act_b}, 0);
      for (int k = 0; k < 2; k++) begin pd[k] = 0; po[k] = 0; pe[k] = 0; end
    end else begin
      for (int c = 0; c < NCH; c++) act_exp[c] = filt_at(last_t, c);
      chk("seu_active_a", act_a, act_exp);
      chk("seu_active_b", act_b, act_exp);
      for (int k = 0; k < 2; k++) begin
        mv  = k ? rv_b : rv_a;
        mo  = k ? ro_b : ro_a;
        me  = k ? re_b : re_a;
        md  = k ? longint'(rd_b) : longint'(rd_a);
        mcw = k ? 8 : 32;
        if (mv) begin
          if (q[k].size() == 0) chk($sformatf("spurious_rd_valid_%0d", k), 1, 0);
          else begin
            ex = q[k].pop_front();
            chk($sformatf("rd_latency_%0d", k), last_t, ex.due);
            chk($sformatf("rd_data_%0d", k), md, exp_val(ex.n, mcw));
            chk($sformatf("rd_ovf_%0d", k), mo, ex.n >= (longint'(1) << mcw));
            chk($sformatf("rd_err_%0d", k), me, ex.err);
          end
        end else begin
          if (q[k].size() != 0 && q[k][0].due <= last_t) begin
            chk($sformatf("missing_rd_valid_%0d", k), 0, 1);
            void'(q[k].pop_front());
          end
          chk($sformatf("rd_hold_%0d", k), {md, mo, me}, {pd[k], po[k], pe[k]});
        end
        pd[k] = md; po[k] = mo; pe[k] = me;
      end
    end
  end

  task automatic drive(input logic [NCH-1:0] s, input logic c, input logic sn,
                       input logic rr, input logic [3:0] sel);
    @(negedge clk);
    seu_in = s; clr = c; snap = sn; rd_req = rr; rd_sel = sel;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic pulse(input int ch);
    logic [NCH-1:0] m;
    m = '0; m[ch] = 1'b1;
    drive(m, 1'b0, 1'b0, 1'b0, 4'd0);
    idle(11);
  endtask

  task automatic snap_read(input logic [3:0] sel);
    drive('0, 1'b0, 1'b1, 1'b0, 4'd0);
    drive('0, 1'b0, 1'b0, 1'b1, sel);
    idle(3);
  endtask

  logic [NCH-1:0] rs;
  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    // single pulse on ch0
    pulse(0);
    snap_read(4'd0);

    // bouncing ch1 every 3 cycles for 30 cycles counts once
    for (int i = 0; i < 10; i++) begin
      drive(4'b0010, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(2);
    end
    idle(12);
    snap_read(4'd1);

    // ch3: five events, then a sixth whose increment meets snap+clr
    drive('0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) pulse(3);
    drive(4'b1000, 1'b0, 1'b0, 1'b0, 4'd0);
    idle(2);
    drive('0, 1'b1, 1'b1, 1'b0, 4'd0);
    drive('0, 1'b0, 1'b0, 1'b1, 4'd3);
    idle(12);
    snap_read(4'd3);

    // out-of-range read, and disabled channel ignores pulses
    drive('0, 1'b0, 1'b0, 1'b1, 4'd9);
    idle(2);
    ch_en[0] = 1'b0;
    for (int i = 0; i < 3; i++) pulse(0);
    ch_en[0] = 1'b1;
    snap_read(4'd0);

    // 256 separated events on ch2 after a clear: wrap / saturate on CW=8
    drive('0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 256; i++) pulse(2);
    snap_read(4'd2);
    pulse(2);
    snap_read(4'd2);

    // randomized traffic, back-to-back reads included
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) rs[c] = ($urandom_range(0, 15) == 0);
      ch_en = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
      drive(rs, $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, NCH - 1))
                                        : 4'($urandom_range(0, 15)));
    end
    ch_en = '1;
    idle(12);
    for (int c = 0; c < NCH; c++) snap_read(4'(c));

    // reset mid-hold and mid-read
    pulse(0);
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 4'd0);
    idle(3);
    drive('0, 1'b0, 1'b1, 1'b0, 4'd0);
    drive('0, 1'b0, 1'b0, 1'b1, 4'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_a", {rv_a, ro_a, re_a, |rd_a, |act_a}, 0);
    chk("rst_async_b", {rv_b, ro_b, re_b, |rd_b, |act_b}, 0);
    drive('0, 1'b0, 1'b0, 1'b0, 4'd0);
    idle(2);
    rst = 1'b0;
    idle(15);
    snap_read(4'd0);
    idle(5);

    chk("queue_drained_a", q[0].size(), 0);
    chk("queue_drained_b", q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
